// File: rtl/apb_wait_slave_if.sv
// APB3 bus bundle between the interconnect and apb_wait_slave.
// The master modport drives the request; the slave modport answers.
interface apb_wait_slave_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_wait_slave.sv
// APB3 register-file slave with a programmable number of wait states.
// Define APB_WAIT_SLV_PSLVERR_EN to flag invalid addresses with pslverr.
module apb_wait_slave #(
   parameter logic [4:0] WAIT_N = 5'd2
) (
   input  logic            clk,
   input  logic            rst,
   apb_wait_slave_if.slave bus
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [4:0]  wait_cfg;
   logic [31:0] regs [0:7];
   logic        pready_q;
   logic [31:0] prdata_q;
   logic        pslverr_q;

   logic [2:0]  idx;
   logic        valid;
   logic [31:0] rd_val;
   logic        err;

   assign idx   = bus.paddr[4:2];
   assign valid = (bus.paddr[7:5] == 3'd0) && (bus.paddr[1:0] == 2'd0);

   // Read data for the current address; zero for writes and bad addresses.
   always_comb begin
      rd_val = '0;
      if (!bus.pwrite && valid) begin
         if (idx == 3'd7) rd_val = {27'd0, wait_cfg};
         else             rd_val = regs[idx];
      end
   end

   // Error response for the current address, only in the checking build.
   always_comb begin
`ifdef APB_WAIT_SLV_PSLVERR_EN
      err = !valid;
`else
      err = 1'b0;
`endif
   end

   // Transfer FSM, wait counter, register file and registered responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
         wait_cfg  <= WAIT_N;
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.psel && !bus.penable) begin
                  state    <= WAIT;
                  cnt      <= wait_cfg;
                  pready_q <= (wait_cfg == 5'd0);
                  if (wait_cfg == 5'd0) begin
                     prdata_q  <= rd_val;
                     pslverr_q <= err;
                  end
               end
            end
            WAIT: begin
               if (!bus.psel) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  pready_q  <= 1'b0;
                  prdata_q  <= '0;
                  pslverr_q <= 1'b0;
               end else if (bus.penable && !pready_q) begin
                  if (cnt != 5'd0) cnt <= cnt - 5'd1;
                  if (cnt == 5'd1) begin
                     pready_q  <= 1'b1;
                     prdata_q  <= rd_val;
                     pslverr_q <= err;
                  end
               end else if (bus.penable) begin
                  if (bus.pwrite && valid) begin
                     if (idx == 3'd7) wait_cfg <= bus.pwdata[4:0];
                     else             regs[idx] <= bus.pwdata;
                  end
                  state     <= IDLE;
                  cnt       <= '0;
                  pready_q  <= 1'b0;
                  prdata_q  <= '0;
                  pslverr_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.pready  = pready_q;
   assign bus.prdata  = prdata_q;
   assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_wait_slave.sv
// Self-checking bench for apb_wait_slave: directed plan plus random traffic
// compared against a register-map model of the slave.
module tb_apb_wait_slave;

   localparam logic [4:0] WN = 5'd2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] m_reg [0:6];
   logic [4:0]  m_cfg;

   apb_wait_slave_if bus ();

   apb_wait_slave #(.WAIT_N(WN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit a_ok(input logic [7:0] a);
      return (a < 8'h20) && (a % 4 == 0);
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] a);
      if (!a_ok(a)) return 32'd0;
      if (a == 8'h1C) return {27'd0, m_cfg};
      return m_reg[a / 4];
   endfunction

   function automatic logic m_err(input logic [7:0] a);
`ifdef APB_WAIT_SLV_PSLVERR_EN
      return !a_ok(a);
`else
      return 1'b0;
`endif
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 7; i++) m_reg[i] = '0;
      m_cfg = WN;
   endtask

   task automatic setup(input bit wr, input logic [7:0] a,
                        input logic [31:0] d);
      @(negedge clk);
      bus.psel = 1'b1; bus.penable = 1'b0;
      bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
      chk("setup_rdy", {31'd0, bus.pready}, 32'd0);
   endtask

   // Full transfer; returns at the negedge of the pready cycle.
   task automatic xfer(input bit wr, input logic [7:0] a,
                       input logic [31:0] d);
      int  n;
      int  w;
      bit  done;
      w = int'(m_cfg);
      setup(wr, a, d);
      n = 0;
      done = 1'b0;
      while (!done && n < 40) begin
         @(negedge clk);
         bus.penable = 1'b1;
         n++;
         if (bus.pready === 1'b1) done = 1'b1;
      end
      chk("acc_len", n, w + 1);
      if (done) begin
         chk("prdata", bus.prdata, wr ? 32'd0 : m_read(a));
         chk("pslverr", {31'd0, bus.pslverr}, {31'd0, m_err(a)});
      end
      if (wr && a_ok(a)) begin
         if (a == 8'h1C) m_cfg = d[4:0];
         else            m_reg[a / 4] = d;
      end
   endtask

   task automatic idle();
      @(negedge clk);
      bus.psel = 1'b0; bus.penable = 1'b0;
      chk("idle_rdy", {31'd0, bus.pready}, 32'd0);
      chk("idle_rd", bus.prdata, 32'd0);
   endtask

   // Setup plus k access cycles, pready required low throughout.
   task automatic partial(input bit wr, input logic [7:0] a,
                          input logic [31:0] d, input int k);
      setup(wr, a, d);
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         bus.penable = 1'b1;
         chk("part_rdy", {31'd0, bus.pready}, 32'd0);
      end
   endtask

   task automatic abort();
      @(negedge clk);
      chk("abort_rdy", {31'd0, bus.pready}, 32'd0);
      bus.psel = 1'b0; bus.penable = 1'b0;
      @(negedge clk);
      chk("post_abort", {31'd0, bus.pready}, 32'd0);
   endtask

   initial begin
      bit          wr;
      logic [7:0]  a;
      logic [31:0] d;
      int          r;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
      bus.paddr = '0; bus.pwdata = '0;
      rst = 1'b1;
      m_reset();
      repeat (2) @(negedge clk);
      chk("rst_rdy", {31'd0, bus.pready}, 32'd0);
      chk("rst_rd", bus.prdata, 32'd0);
      chk("rst_err", {31'd0, bus.pslverr}, 32'd0);
      rst = 1'b0;

      xfer(1'b0, 8'h1C, 32'd0);
      xfer(1'b0, 8'h00, 32'd0);
      idle();

      xfer(1'b1, 8'h1C, 32'd0);
      xfer(1'b1, 8'h08, 32'hDEADBEEF);
      xfer(1'b0, 8'h08, 32'd0);
      idle();

      xfer(1'b1, 8'h1C, 32'd31);
      xfer(1'b0, 8'h04, 32'd0);
      idle();

      xfer(1'b1, 8'h1C, 32'd3);
      xfer(1'b1, 8'h0C, 32'h0000_1234);
      idle();
      partial(1'b1, 8'h0C, 32'hFFFF_FFFF, 2);
      abort();
      xfer(1'b0, 8'h0C, 32'd0);

      xfer(1'b1, 8'h20, 32'hCAFE_F00D);
      xfer(1'b0, 8'h1E, 32'd0);
      xfer(1'b0, 8'h00, 32'd0);
      idle();

      xfer(1'b1, 8'h10, 32'h5555_AAAA);
      idle();
      partial(1'b1, 8'h10, 32'h1111_2222, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_rdy", {31'd0, bus.pready}, 32'd0);
      chk("mid_rst_rd", bus.prdata, 32'd0);
      chk("mid_rst_err", {31'd0, bus.pslverr}, 32'd0);
      rst = 1'b0;
      bus.psel = 1'b0; bus.penable = 1'b0;
      m_reset();
      xfer(1'b0, 8'h1C, 32'd0);
      xfer(1'b0, 8'h10, 32'd0);
      idle();

      for (int it = 0; it < 80; it++) begin
         r = int'($urandom_range(0, 9));
         a = (r < 8) ? 8'(r * 4) : 8'($urandom);
         wr = 1'($urandom);
         d = $urandom;
         if (a == 8'h1C) d = 32'($urandom_range(0, 5));
         if (m_cfg != 5'd0 && $urandom_range(0, 7) == 0) begin
            partial(wr, a, d, int'($urandom_range(0, int'(m_cfg) - 1)));
            abort();
         end else begin
            xfer(wr, a, d);
            if ($urandom_range(0, 1) == 0) idle();
         end
      end
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
